// File: rtl/pipeline_ctrl_pkg.sv
// Shared types for the pipeline latch controller: FSM state encoding and latch indices.
// No logic of its own; no latency; no backpressure.
// Latch indices run oldest-last: IF/ID is bit 0, MEM/WB is bit 3.
package pipeline_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        HALTED = 2'd2
    } pctrl_state_t;

    localparam int IFID  = 0;
    localparam int IDEX  = 1;
    localparam int EXMEM = 2;
    localparam int MEMWB = 3;

endpackage

// File: rtl/pipeline_ctrl_if.sv
// Hazard-unit to latch-controller bundle; PIPE_PERF_EN adds the counter outputs.
// Pure wiring, zero latency.
// No backpressure: every field is a per-cycle level.
interface pipeline_ctrl_if #(
    parameter int NSTAGE = 4
`ifdef PIPE_PERF_EN
    , parameter int PERF_W = 32
`endif
);
    logic              stall;
    logic              flush;
    logic              halttype;
    logic              ihit;
    logic              dmem_req;
    logic              dhit;
    logic              pc_en;
    logic [NSTAGE-1:0] lat_en;
    logic [NSTAGE-1:0] lat_flush;
    logic [NSTAGE-1:0] stage_valid;
    logic              halt;
    logic [1:0]        state_o;
`ifdef PIPE_PERF_EN
    logic [PERF_W-1:0] stall_cnt;
    logic [PERF_W-1:0] flush_cnt;
    logic [PERF_W-1:0] memwait_cnt;

    modport master (
        output stall, flush, halttype, ihit, dmem_req, dhit,
        input  pc_en, lat_en, lat_flush, stage_valid, halt, state_o,
               stall_cnt, flush_cnt, memwait_cnt
    );
    modport slave (
        input  stall, flush, halttype, ihit, dmem_req, dhit,
        output pc_en, lat_en, lat_flush, stage_valid, halt, state_o,
               stall_cnt, flush_cnt, memwait_cnt
    );
`else
    modport master (
        output stall, flush, halttype, ihit, dmem_req, dhit,
        input  pc_en, lat_en, lat_flush, stage_valid, halt, state_o
    );
    modport slave (
        input  stall, flush, halttype, ihit, dmem_req, dhit,
        output pc_en, lat_en, lat_flush, stage_valid, halt, state_o
    );
`endif
endinterface

// File: rtl/pipe_valid_track.sv
// Per-latch valid bits plus the halt token that rides down the pipe with the halt instruction.
// One-cycle update: registered state follows lat_en/lat_flush at each edge.
// Held latches (lat_en=0) keep their bits, which is how freezes are honoured.
module pipe_valid_track #(
    parameter int NSTAGE = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ihit,
    input  logic              tok_load,
    input  logic [NSTAGE-1:0] lat_en,
    input  logic [NSTAGE-1:0] lat_flush,
    output logic [NSTAGE-1:0] stage_valid,
    output logic              tok_last
);
    logic [NSTAGE-1:0] valid_q, valid_d;
    logic [NSTAGE-1:0] tok_q, tok_d, tok_cur;

    always_comb begin
        // A halt decoded this cycle sits in IF/ID now, so it moves on at the same edge.
        tok_cur    = tok_q;
        tok_cur[0] = tok_q[0] | tok_load;
        valid_d    = valid_q;
        tok_d      = tok_q;
        if (lat_en[0]) begin
            valid_d[0] = ihit & ~lat_flush[0];
            tok_d[0]   = 1'b0;
        end else begin
            tok_d[0]   = tok_cur[0];
        end
        for (int i = 1; i < NSTAGE; i++) begin
            if (lat_en[i]) begin
                valid_d[i] = valid_q[i-1] & ~lat_flush[i];
                tok_d[i]   = tok_cur[i-1] & ~lat_flush[i];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            tok_q   <= '0;
        end else begin
            valid_q <= valid_d;
            tok_q   <= tok_d;
        end
    end

    assign stage_valid = valid_q;
    assign tok_last    = tok_q[NSTAGE-1];

endmodule

// File: rtl/pipeline_ctrl.sv
// Latch/PC enable controller with halt-drain FSM; PIPE_PERF_EN adds saturating perf counters.
// Enables are combinational from inputs and state; stage_valid/halt update at the next edge.
// Memory wait freezes every latch and the PC; in HALTED all inputs are ignored until reset.
module pipeline_ctrl
    import pipeline_ctrl_pkg::*;
#(
    parameter int NSTAGE = 4
`ifdef PIPE_PERF_EN
    , parameter int PERF_W = 32
`endif
) (
    input  logic            CLK,
    input  logic            nRST,
    pipeline_ctrl_if.slave  bus
);
    pctrl_state_t      state_q, state_d;
    logic              halt_q, halt_d;
    logic              pc_en;
    logic [NSTAGE-1:0] lat_en, lat_flush;
    logic [NSTAGE-1:0] stage_valid;
    logic              mem_wait, tok_load, tok_last;

    assign mem_wait = bus.dmem_req & ~bus.dhit;

    always_comb begin
        state_d   = state_q;
        halt_d    = halt_q;
        pc_en     = 1'b0;
        lat_en    = '0;
        lat_flush = '0;
        tok_load  = 1'b0;
        if (!nRST) begin
            lat_flush = '1;
        end else begin
            case (state_q)
                RUN: begin
                    if (mem_wait) begin
                        lat_en = '0;
                    end else if (bus.flush) begin
                        pc_en            = 1'b1;
                        lat_en           = '1;
                        lat_flush[IFID]  = 1'b1;
                        lat_flush[IDEX]  = 1'b1;
                    end else if (bus.stall) begin
                        lat_en           = '1;
                        lat_en[IFID]     = 1'b0;
                        lat_flush[IDEX]  = 1'b1;
                    end else if (!bus.ihit) begin
                        lat_en           = '1;
                        lat_flush[IFID]  = 1'b1;
                    end else begin
                        pc_en            = 1'b1;
                        lat_en           = '1;
                    end
                    if (bus.halttype && !bus.flush) begin
                        tok_load = 1'b1;
                        state_d  = DRAIN;
                    end
                end
                DRAIN: begin
                    // Fetch is shut off; only older instructions keep moving.
                    lat_flush[IFID] = 1'b1;
                    if (mem_wait) begin
                        lat_en = '0;
                    end else if (bus.stall) begin
                        lat_en          = '1;
                        lat_en[IFID]    = 1'b0;
                        lat_flush[IDEX] = 1'b1;
                    end else begin
                        lat_en = '1;
                    end
                    if (tok_last && lat_en[MEMWB]) begin
                        state_d = HALTED;
                        halt_d  = 1'b1;
                    end
                end
                HALTED: begin
                    state_d = HALTED;
                end
                default: begin
                    state_d = RUN;
                end
            endcase
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q <= RUN;
            halt_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            halt_q  <= halt_d;
        end
    end

    pipe_valid_track #(.NSTAGE(NSTAGE)) u_track (
        .clk         (CLK),
        .rst_n       (nRST),
        .ihit        (bus.ihit),
        .tok_load    (tok_load),
        .lat_en      (lat_en),
        .lat_flush   (lat_flush),
        .stage_valid (stage_valid),
        .tok_last    (tok_last)
    );

    assign bus.pc_en       = pc_en;
    assign bus.lat_en      = lat_en;
    assign bus.lat_flush   = lat_flush;
    assign bus.stage_valid = stage_valid;
    assign bus.halt        = halt_q;
    assign bus.state_o     = state_q;

`ifdef PIPE_PERF_EN
    logic              active, win_mem, win_flush, win_stall;
    logic [PERF_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [PERF_W-1:0] flush_cnt_q, flush_cnt_d;
    logic [PERF_W-1:0] memwait_cnt_q, memwait_cnt_d;

    always_comb begin
        active    = nRST && (state_q == RUN || state_q == DRAIN);
        win_mem   = active & mem_wait;
        win_flush = active & (state_q == RUN) & ~mem_wait & bus.flush;
        win_stall = active & ~mem_wait & ~win_flush & bus.stall;
        stall_cnt_d   = (win_stall && !(&stall_cnt_q))   ? stall_cnt_q + 1'b1   : stall_cnt_q;
        flush_cnt_d   = (win_flush && !(&flush_cnt_q))   ? flush_cnt_q + 1'b1   : flush_cnt_q;
        memwait_cnt_d = (win_mem   && !(&memwait_cnt_q)) ? memwait_cnt_q + 1'b1 : memwait_cnt_q;
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            stall_cnt_q   <= '0;
            flush_cnt_q   <= '0;
            memwait_cnt_q <= '0;
        end else begin
            stall_cnt_q   <= stall_cnt_d;
            flush_cnt_q   <= flush_cnt_d;
            memwait_cnt_q <= memwait_cnt_d;
        end
    end

    assign bus.stall_cnt   = stall_cnt_q;
    assign bus.flush_cnt   = flush_cnt_q;
    assign bus.memwait_cnt = memwait_cnt_q;
`endif

endmodule

// File: doc/pipeline_ctrl.md
Name: pipeline_ctrl

Overview:
- Consumer end of the hazard-unit handshake. Takes the hazard unit's stall, flush and halttype decisions and the cache hit signals.
- Drives the per-latch enable and flush controls for IF/ID, ID/EX, EX/MEM and MEM/WB, plus the PC enable.
- Tracks stage validity and a halt token. Runs a halt-drain FSM that raises the sticky CPU halt only after the halt instruction retires.

Parameters:
- NSTAGE, 4, number of pipeline latches controlled (IF/ID..MEM/WB).
- PERF_W, 32, width of performance counters (used only with PIPE_PERF_EN).

Ports:
- CLK  in  1  system clock, rising edge.
- nRST  in  1  asynchronous active-low reset.
- stall  in  1  hazard unit: load-use stall request.
- flush  in  1  hazard unit: branch/jump flush request.
- halttype  in  1  hazard unit: halt decoded in ID this cycle.
- ihit  in  1  instruction fetch complete.
- dmem_req  in  1  MEM stage has dren or dwen active.
- dhit  in  1  data access complete.
- pc_en  out  1  PC register update enable.
- lat_en  out  NSTAGE  per-latch enable; bit0=IF/ID … bit3=MEM/WB.
- lat_flush  out  NSTAGE  per-latch synchronous clear (bubble insert).
- stage_valid  out  NSTAGE  registered valid bit per latch.
- halt  out  1  sticky CPU halt.
- state_o  out  2  current FSM state (debug).

Behaviour:
- Reset (async, nRST=0): state=RUN, stage_valid=0, halt token=0, halt=0.
- Combinational outputs are evaluated from the reset state: pc_en=0, lat_en=0, lat_flush=all ones.
- FSM states and encodings: RUN=0, DRAIN=1, HALTED=2. Encoding 3 is illegal and returns to RUN.
- Priority of combinational control, highest first: HALTED > memory wait > flush > stall > fetch miss > normal.
- Memory wait (dmem_req & !dhit): all lat_en=0, pc_en=0, lat_flush=0. The whole pipe freezes and state is held.
- flush: pc_en=1, lat_en all 1, lat_flush[0]=1, lat_flush[1]=1. The two younger latches are squashed.
- stall: pc_en=0, lat_en[0]=0 (IF/ID holds), lat_flush[1]=1 (bubble into EX), lat_en[3:2]=1.
- Fetch miss (!ihit, no flush/stall): pc_en=0, lat_flush[0]=1, downstream latches advance.
- Normal: pc_en=1, lat_en all 1, lat_flush=0.
- stage_valid update each cycle a latch is enabled:
  - bit0 takes ihit & !lat_flush[0];
  - bit i takes stage_valid[i-1] & !lat_flush[i].
  - A held latch keeps its bit.
- Halt token: a 4-bit shift register, loaded into bit0 when halttype is seen in RUN, shifted alongside the latch enables.
- RUN -> DRAIN: on halttype, unless flush is asserted the same cycle. A flush wins and the halt is squashed.
- In DRAIN:
  - pc_en=0 and lat_flush[0]=1 every cycle, so no new fetches enter.
  - Downstream latches obey the memory-wait and stall rules.
- DRAIN -> HALTED: the cycle the halt token is in bit3 and lat_en[3]=1.
- In HALTED:
  - halt=1 (registered, set on the transition edge);
  - pc_en=0 and lat_en=0;
  - all inputs are ignored until reset.
- Reset asserted mid-DRAIN or in HALTED returns to RUN immediately and clears halt.
- stall and flush asserted together: flush wins; the stall is not honoured that cycle.

Optional Feature:
- Macro: PIPE_PERF_EN.
- With the macro defined, adds outputs stall_cnt, flush_cnt, memwait_cnt (PERF_W each).
- Each counter increments by 1 on cycles where its condition is the winning priority. Counters saturate at all-ones, reset to 0 and freeze in HALTED.
- Without the macro, these ports and registers do not exist; all other behaviour is identical.

Decomposition:
- cpu_types_pkg gains:
  - typedef enum logic [1:0] pctrl_state_t {RUN, DRAIN, HALTED};
  - localparams IFID=0, IDEX=1, EXMEM=2, MEMWB=3 for latch indexing.
- One natural sub-module, pipe_valid_track: the stage_valid and halt-token shift logic, parameterised by NSTAGE, driven by lat_en/lat_flush.

Test Plan:
- Reset: hold nRST=0 for 2 cycles with random inputs -> halt=0, stage_valid=0000, lat_flush=1111, state_o=0.
- Load-use: ihit=1, pulse stall for 1 cycle -> that cycle pc_en=0, lat_en[0]=0, lat_flush[1]=1; next cycle stage_valid[1]=0.
- Branch: flush=1 and stall=1 together -> pc_en=1, lat_flush=0011; stage_valid[1:0]=00 after the edge.
- Memory wait: dmem_req=1, dhit=0 for 5 cycles then dhit=1 -> lat_en=0000 for 5 cycles, stage_valid unchanged, advance on the 6th.
- Halt drain: pulse halttype with ihit=1, no stalls -> DRAIN next cycle; halt=1 exactly 3 cycles after the DRAIN entry edge, with pc_en=0 throughout. Repeat with a 2-cycle dmem wait -> halt delayed by 2 cycles.
- Squashed halt, then reset: halttype and flush together -> state stays RUN, halt=0. Then drive nRST low while in HALTED -> halt=0, state RUN.
